// File: rtl/tl_pkg.sv
// Shared types for the intersection controller and the light datapath.
// Lamp encodings are fixed by the signal heads; 2'b11 is never driven.
package tl_pkg;

  typedef enum logic [1:0] {
    RED    = 2'b00,
    GREEN  = 2'b01,
    YELLOW = 2'b10
  } light_t;

  typedef enum logic [2:0] {
    ALL_RED,
    NS_GREEN,
    NS_YELLOW,
    EW_GREEN,
    EW_YELLOW,
    PED_WALK
  } ctrl_state_t;

  typedef enum logic {
    NS = 1'b0,
    EW = 1'b1
  } dir_t;

endpackage

// File: rtl/tl_dwell_timer.sv
// Dwell counter: restarts at 0 on clear, counts up each cycle, and flags the
// last cycle of a dwell. The dwell is one bit wider so that 2^CW is legal.
module tl_dwell_timer #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic [CW:0]   dwell,
  output logic [CW-1:0] count,
  output logic          last
);

  always_ff @(posedge clk) begin
    if (reset || clear) count <= '0;
    else                count <= count + 1'b1;
  end

  assign last = ({1'b0, count} == (dwell - {{CW{1'b0}}, 1'b1}));

endmodule

// File: rtl/intersection_ctrl.sv
// Two-phase intersection controller with pedestrian walk phase.
// Lamps and walk are a Moore decode of the registered state.
module intersection_ctrl
  import tl_pkg::*;
#(
  parameter int RED_CLR   = 2,
  parameter int GREEN_MIN = 6,
  parameter int GREEN_MAX = 12,
  parameter int YELLOW_T  = 3,
  parameter int WALK_T    = 5,
  parameter int CW        = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ns_car,
  input  logic       ew_car,
  input  logic       ped_req,
  output logic [1:0] light_ns,
  output logic [1:0] light_ew,
  output logic       walk,
  output logic       ped_pend
);

  localparam int DMAX = 1 << CW;

  if (RED_CLR < 1 || RED_CLR > DMAX) begin : g_bad_red_clr
    $error("RED_CLR out of range");
  end
  if (GREEN_MIN < 1 || GREEN_MIN > DMAX) begin : g_bad_green_min
    $error("GREEN_MIN out of range");
  end
  if (GREEN_MAX < 1 || GREEN_MAX > DMAX || GREEN_MAX < GREEN_MIN) begin : g_bad_green_max
    $error("GREEN_MAX out of range or below GREEN_MIN");
  end
  if (YELLOW_T < 1 || YELLOW_T > DMAX) begin : g_bad_yellow
    $error("YELLOW_T out of range");
  end
  if (WALK_T < 1 || WALK_T > DMAX) begin : g_bad_walk
    $error("WALK_T out of range");
  end

  typedef logic [CW:0] dwell_t;
  localparam dwell_t RED_D  = dwell_t'(RED_CLR);
  localparam dwell_t GMIN_D = dwell_t'(GREEN_MIN);
  localparam dwell_t GMAX_D = dwell_t'(GREEN_MAX);
  localparam dwell_t YEL_D  = dwell_t'(YELLOW_T);
  localparam dwell_t WALK_D = dwell_t'(WALK_T);

  ctrl_state_t   state, state_next;
  dir_t          next_dir;
  dwell_t        dwell;
  logic [CW-1:0] count;
  logic          last;
  logic          clear;
  logic          ns_demand, ew_demand;
  light_t        ns_lamp, ew_lamp;

  tl_dwell_timer #(.CW(CW)) u_timer (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .dwell (dwell),
    .count (count),
    .last  (last)
  );

  assign ns_demand = ew_car | ped_pend;
  assign ew_demand = ns_car | ped_pend;
  assign clear     = (state_next != state);

  always_ff @(posedge clk) begin
    if (reset) state <= ALL_RED;
    else       state <= state_next;
  end

  // Green compares against GREEN_MIN only while the minimum point is still
  // ahead; past it, only GREEN_MAX can end the phase.
  always_comb begin
    state_next = state;
    dwell      = RED_D;
    case (state)
      ALL_RED: begin
        dwell = RED_D;
        if (last) begin
          if (ped_pend)            state_next = PED_WALK;
          else if (next_dir == NS) state_next = NS_GREEN;
          else                     state_next = EW_GREEN;
        end
      end
      NS_GREEN: begin
        dwell = (ns_demand && ({1'b0, count} < GMIN_D)) ? GMIN_D : GMAX_D;
        if (last) state_next = NS_YELLOW;
      end
      NS_YELLOW: begin
        dwell = YEL_D;
        if (last) state_next = ALL_RED;
      end
      EW_GREEN: begin
        dwell = (ew_demand && ({1'b0, count} < GMIN_D)) ? GMIN_D : GMAX_D;
        if (last) state_next = EW_YELLOW;
      end
      EW_YELLOW: begin
        dwell = YEL_D;
        if (last) state_next = ALL_RED;
      end
      PED_WALK: begin
        dwell = WALK_D;
        if (last) state_next = (next_dir == NS) ? NS_GREEN : EW_GREEN;
      end
      default: state_next = ALL_RED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)                                              next_dir <= NS;
    else if (state_next == NS_YELLOW && state != NS_YELLOW) next_dir <= EW;
    else if (state_next == EW_YELLOW && state != EW_YELLOW) next_dir <= NS;
  end

  // Walk entry clears the latch; presses during the walk itself are dropped.
  always_ff @(posedge clk) begin
    if (reset)                                            ped_pend <= 1'b0;
    else if (state_next == PED_WALK && state != PED_WALK) ped_pend <= 1'b0;
    else if (ped_req && state != PED_WALK)                ped_pend <= 1'b1;
  end

  always_comb begin
    ns_lamp = RED;
    ew_lamp = RED;
    walk    = 1'b0;
    case (state)
      NS_GREEN:  ns_lamp = GREEN;
      NS_YELLOW: ns_lamp = YELLOW;
      EW_GREEN:  ew_lamp = GREEN;
      EW_YELLOW: ew_lamp = YELLOW;
      PED_WALK:  walk    = 1'b1;
      default: ;
    endcase
  end

  assign light_ns = ns_lamp;
  assign light_ew = ew_lamp;

endmodule

// File: tb/tb_intersection_ctrl.sv
// Bench for intersection_ctrl: directed vector tables built from the
// expected phase timing, followed by a randomized safety run.
module tb_intersection_ctrl;

  localparam logic [1:0] R = 2'b00;
  localparam logic [1:0] G = 2'b01;
  localparam logic [1:0] Y = 2'b10;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       ns_car = 1'b0;
  logic       ew_car = 1'b0;
  logic       ped_req = 1'b0;
  logic [1:0] light_ns, light_ew;
  logic       walk, ped_pend;

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    logic       rst;
    logic       ns;
    logic       ew;
    logic       ped;
    logic [1:0] e_ns;
    logic [1:0] e_ew;
    logic       e_walk;
    logic       e_pend;
  } vec_t;

  vec_t       vecs[$];
  logic [5:0] exp_q[$];

  intersection_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .ns_car   (ns_car),
    .ew_car   (ew_car),
    .ped_req  (ped_req),
    .light_ns (light_ns),
    .light_ew (light_ew),
    .walk     (walk),
    .ped_pend (ped_pend)
  );

  always #5 clk = ~clk;

  // Each record: inputs held across one rising edge, outputs expected after it.
  task automatic add(input logic rst, input logic ns, input logic ew, input logic ped,
                     input logic [1:0] e_ns, input logic [1:0] e_ew,
                     input logic e_walk, input logic e_pend, input int n);
    vec_t v;
    v.rst = rst; v.ns = ns; v.ew = ew; v.ped = ped;
    v.e_ns = e_ns; v.e_ew = e_ew; v.e_walk = e_walk; v.e_pend = e_pend;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  task automatic run_vectors(input string name);
    logic [5:0] got, exp;
    for (int i = 0; i < vecs.size(); i++) begin
      reset   = vecs[i].rst;
      ns_car  = vecs[i].ns;
      ew_car  = vecs[i].ew;
      ped_req = vecs[i].ped;
      exp_q.push_back({vecs[i].e_ns, vecs[i].e_ew, vecs[i].e_walk, vecs[i].e_pend});
      @(posedge clk);
      #1;
      got = {light_ns, light_ew, walk, ped_pend};
      exp = exp_q.pop_front();
      compared++;
      if (got !== exp) begin
        mismatched++;
        $display("FAIL %s vec %0d: got ns=%b ew=%b walk=%b pend=%b, want ns=%b ew=%b walk=%b pend=%b",
                 name, i, got[5:4], got[3:2], got[1], got[0], exp[5:4], exp[3:2], exp[1], exp[0]);
      end
    end
    vecs.delete();
    reset = 1'b0; ns_car = 1'b0; ew_car = 1'b0; ped_req = 1'b0;
  endtask

  task automatic random_safety(input int cycles);
    int         red_run;
    logic       prev_walk;
    logic [1:0] prev_ns, prev_ew;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    red_run = 1; prev_walk = 1'b0; prev_ns = R; prev_ew = R;
    for (int c = 0; c < cycles; c++) begin
      ns_car  = 1'($urandom_range(0, 1));
      ew_car  = 1'($urandom_range(0, 1));
      ped_req = ($urandom_range(0, 15) == 0);
      @(posedge clk);
      #1;
      compared++;
      if (light_ns == 2'b11 || light_ew == 2'b11 || (light_ns == G && light_ew == G) ||
          (walk && (light_ns != R || light_ew != R))) begin
        mismatched++;
        $display("FAIL safety cycle %0d: ns=%b ew=%b walk=%b, want legal non-conflicting lamps",
                 c, light_ns, light_ew, walk);
      end
      if ((light_ns == G && prev_ns != G) || (light_ew == G && prev_ew != G)) begin
        compared++;
        if (!(prev_walk || red_run >= 2)) begin
          mismatched++;
          $display("FAIL green_onset cycle %0d: red_run=%0d prev_walk=%b, want red_run>=2 or walk",
                   c, red_run, prev_walk);
        end
      end
      if (light_ns == R && light_ew == R) red_run++;
      else                                red_run = 0;
      prev_walk = walk; prev_ns = light_ns; prev_ew = light_ew;
    end
    ns_car = 1'b0; ew_car = 1'b0; ped_req = 1'b0;
  endtask

  initial begin
    @(posedge clk);
    #1;

    // Idle cycling with no demand: full GREEN_MAX on both approaches.
    add(1, 0, 0, 0, R, R, 0, 0, 1);
    add(0, 0, 0, 0, R, R, 0, 0, 1);
    add(0, 0, 0, 0, G, R, 0, 0, 12);
    add(0, 0, 0, 0, Y, R, 0, 0, 3);
    add(0, 0, 0, 0, R, R, 0, 0, 2);
    add(0, 0, 0, 0, R, G, 0, 0, 12);
    add(0, 0, 0, 0, R, Y, 0, 0, 3);
    add(0, 0, 0, 0, R, R, 0, 0, 2);
    add(0, 0, 0, 0, G, R, 0, 0, 12);
    run_vectors("idle");

    // Opposing EW car held: NS green cut to GREEN_MIN, EW keeps GREEN_MAX.
    add(1, 0, 1, 0, R, R, 0, 0, 1);
    add(0, 0, 1, 0, R, R, 0, 0, 1);
    add(0, 0, 1, 0, G, R, 0, 0, 6);
    add(0, 0, 1, 0, Y, R, 0, 0, 3);
    add(0, 0, 1, 0, R, R, 0, 0, 2);
    add(0, 0, 1, 0, R, G, 0, 0, 12);
    add(0, 0, 1, 0, R, Y, 0, 0, 3);
    add(0, 0, 1, 0, R, R, 0, 0, 2);
    add(0, 0, 1, 0, G, R, 0, 0, 6);
    add(0, 0, 1, 0, Y, R, 0, 0, 1);
    run_vectors("ew_car_held");

    // Single-cycle ped press in second NS green cycle.
    add(1, 0, 0, 0, R, R, 0, 0, 1);
    add(0, 0, 0, 0, R, R, 0, 0, 1);
    add(0, 0, 0, 0, G, R, 0, 0, 2);
    add(0, 0, 0, 1, G, R, 0, 1, 1);
    add(0, 0, 0, 0, G, R, 0, 1, 3);
    add(0, 0, 0, 0, Y, R, 0, 1, 3);
    add(0, 0, 0, 0, R, R, 0, 1, 2);
    add(0, 0, 0, 0, R, R, 1, 0, 5);
    add(0, 0, 0, 0, R, G, 0, 0, 12);
    add(0, 0, 0, 0, R, Y, 0, 0, 1);
    run_vectors("ped_pulse");

    // Ped held through the walk: ignored there, relatched in EW green.
    add(1, 0, 0, 0, R, R, 0, 0, 1);
    add(0, 0, 0, 0, R, R, 0, 0, 1);
    add(0, 0, 0, 0, G, R, 0, 0, 2);
    add(0, 0, 0, 1, G, R, 0, 1, 4);
    add(0, 0, 0, 1, Y, R, 0, 1, 3);
    add(0, 0, 0, 1, R, R, 0, 1, 2);
    add(0, 0, 0, 1, R, R, 1, 0, 5);
    add(0, 0, 0, 1, R, G, 0, 0, 1);
    add(0, 0, 0, 1, R, G, 0, 1, 1);
    add(0, 0, 0, 0, R, G, 0, 1, 4);
    add(0, 0, 0, 0, R, Y, 0, 1, 3);
    add(0, 0, 0, 0, R, R, 0, 1, 2);
    add(0, 0, 0, 0, R, R, 1, 0, 5);
    add(0, 0, 0, 0, G, R, 0, 0, 12);
    run_vectors("ped_held");

    // Press in the deciding all-red cycle: latched, served one cycle later.
    add(1, 0, 0, 0, R, R, 0, 0, 1);
    add(0, 0, 0, 0, R, R, 0, 0, 1);
    add(0, 0, 0, 1, G, R, 0, 1, 1);
    add(0, 0, 0, 0, G, R, 0, 1, 5);
    add(0, 0, 0, 0, Y, R, 0, 1, 3);
    add(0, 0, 0, 0, R, R, 0, 1, 2);
    add(0, 0, 0, 0, R, R, 1, 0, 5);
    add(0, 0, 0, 0, R, G, 0, 0, 12);
    run_vectors("ped_at_decision");

    // Reset during EW yellow with a pending request discards it.
    add(1, 0, 0, 0, R, R, 0, 0, 1);
    add(0, 0, 0, 0, R, R, 0, 0, 1);
    add(0, 0, 0, 0, G, R, 0, 0, 12);
    add(0, 0, 0, 0, Y, R, 0, 0, 3);
    add(0, 0, 0, 0, R, R, 0, 0, 2);
    add(0, 0, 0, 0, R, G, 0, 0, 1);
    add(0, 0, 0, 1, R, G, 0, 1, 1);
    add(0, 0, 0, 0, R, G, 0, 1, 4);
    add(0, 0, 0, 0, R, Y, 0, 1, 1);
    add(1, 0, 0, 1, R, R, 0, 0, 1);
    add(0, 0, 0, 0, R, R, 0, 0, 1);
    add(0, 0, 0, 0, G, R, 0, 0, 3);
    run_vectors("reset_in_ew_yellow");

    random_safety(10000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
